lfsr_rng: RTL and testbench
===========================

// Module: lfsr_rng
// PURPOSE
//  Parametrised Fibonacci LFSR random source with seed load, lock-up protection and a
//  request/valid bounded-draw engine returning uniform values in [0, limit). Feeds game
//  logic (spawn position/timing); free-running state also exported for raw random bits.
// PARAMETERS
//  WIDTH        8      LFSR/state/value width (>=3)
//  TAPS         8'hB8  feedback mask; fb = ^(state & TAPS); default is maximal (period 255)
//  DEFAULT_SEED 1      state after reset and substitute for an all-zero seed; must be non-zero
//  MAX_TRIES    4      rejection-sampling attempts before fallback (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  clr        in   1      synchronous, active-low reset
//  en         in   1      free-run step enable
//  load       in   1      load seed this cycle
//  seed       in   WIDTH  seed value
//  req        in   1      draw request (accepted when req & ready)
//  limit      in   WIDTH  exclusive upper bound, sampled at acceptance
//  ready      out  1      FSM in IDLE, can accept req
//  valid      out  1      value holds a completed draw
//  ack        in   1      consumer takes value (completes when valid & ack)
//  value      out  WIDTH  drawn value, < limit (0 if limit==0)
//  state_out  out  WIDTH  current LFSR register
//  lockup_err out  1      sticky: all-zero state was detected and repaired
// BEHAVIOUR
//  Step: state <= {state[WIDTH-2:0], ^(state & TAPS)}.
//  Reset (clr==0 at edge): state=DEFAULT_SEED, FSM=IDLE, ready=1, valid=0, value=0,
//   lockup_err=0; overrides all other inputs, including mid-draw (draw abandoned).
//  State update priority: reset > load > step. load: state <= (seed==0) ? DEFAULT_SEED : seed.
//  Step occurs once per cycle when en=1 or FSM in DRAW (never double-steps).
//  Lock-up: if state==0 (bad TAPS or upset), next state = DEFAULT_SEED, lockup_err <= 1 until reset.
//  FSM states IDLE, DRAW, DONE:
//   IDLE: ready=1. req&ready -> lim_q<=limit, tries<=0, mask<=smallest 2^k-1 >= limit-1
//    (limit<=1 gives mask 0); limit==0 or 1 -> value<=0, go DONE; else go DRAW.
//   DRAW: ready=0. cand = state & mask (current register, before this cycle's step).
//    cand < lim_q -> value<=cand, DONE. Else if tries==MAX_TRIES-1 -> value<=cand-lim_q
//    (always < lim_q since cand<=mask<2*lim_q), DONE. Else tries++ and stay.
//   DONE: valid=1, value stable; valid&ack -> IDLE (ready next cycle). req ignored unless ready.
//  Latency: accept at edge N -> DRAW evaluated in cycle N+1 -> valid from cycle N+2 (best
//   case); worst case valid at N+1+MAX_TRIES. limit<2: valid at N+1.
//  load during DRAW: loaded state used from next cycle; draw continues, tries not reset.
//  load+req same cycle: limit captured; first candidate uses loaded state.
//  Arithmetic unsigned, WIDTH bits, no overflow (cand-lim_q only when cand>=lim_q).
// TESTING
//  Reset, en=1 4 cycles (defaults) -> state_out 01,02,04,08,11; 255 steps return to 01.
//  load seed=0 -> state_out=01; load seed=8'h5A with en=1 same cycle -> state_out=5A (no step).
//  state=01, req limit=10 -> ready low, valid at accept+2, value=1; hold ack=0 5 cycles ->
//   value/valid stable; ack -> ready next cycle.
//  MAX_TRIES=1, load seed=0F, req limit=9 -> cand=15 rejected -> fallback value=6.
//  limit=0 and limit=1 -> value=0, valid one cycle after accept, no LFSR step.
//  clr low mid-DRAW -> next cycle valid=0, ready=1, state_out=01; force state 0 -> lockup_err=1, state 01.

Source files
------------

// File: rtl/lfsr_rng_if.sv
// Draw request/response bundle between a consumer and lfsr_rng.
// Handshake: a request transfers on a clock edge where req && ready; the result
// transfers on an edge where valid && ack. valid holds and value stays stable until then.
interface lfsr_rng_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic [WIDTH-1:0] limit;
  logic             ready;
  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] value;

  modport master (output req, output limit, output ack,
                  input  ready, input valid, input value);
  modport slave  (input  req, input limit, input ack,
                  output ready, output valid, output value);
endinterface

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source with seed load, lock-up repair and a bounded
// draw engine that returns uniform values in [0, limit) via rejection sampling.
module lfsr_rng #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  parameter int               MAX_TRIES    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  lfsr_rng_if.slave        bus,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup_err,
  output logic [1:0]       fsm_dbg
);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_step;
  logic [WIDTH-1:0] lim_q, mask_q, value_q, cand;
  logic [TW-1:0]    tries;
  logic             accept, hit, last_try, stepping;

  // Smallest all-ones mask covering lim-1; degenerate limits draw nothing.
  function automatic logic [WIDTH-1:0] mask_for(input logic [WIDTH-1:0] lim);
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] r;
    r = '0;
    m = lim - WIDTH'(1);
    if (lim >= WIDTH'(2)) begin
      for (int i = 0; i < WIDTH; i++) r[i] = |(m >> i);
    end
    return r;
  endfunction

  assign lfsr_step = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign accept    = (fsm == IDLE) && bus.req;
  assign cand      = lfsr & mask_q;
  assign hit       = cand < lim_q;
  assign last_try  = (tries == TW'(MAX_TRIES - 1));
  assign stepping  = en || (fsm == DRAW);
  assign state_out = lfsr;

  always_ff @(posedge clk) begin
    if (!clr) begin
      lfsr       <= DEFAULT_SEED;
      lockup_err <= 1'b0;
    end else if (load) begin
      lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
    end else if (lfsr == '0) begin
      // All-zero is a fixed point of any XOR feedback; kick it back to the seed.
      lfsr       <= DEFAULT_SEED;
      lockup_err <= 1'b1;
    end else if (stepping) begin
      lfsr <= lfsr_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) fsm <= IDLE;
    else      fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (bus.req) fsm_nxt = (bus.limit < WIDTH'(2)) ? DONE : DRAW;
      DRAW:    if (hit || last_try) fsm_nxt = DONE;
      DONE:    if (bus.ack) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (fsm == IDLE);
    bus.valid = (fsm == DONE);
    bus.value = value_q;
    fsm_dbg   = fsm;
  end

  // Since mask < 2*lim, a rejected candidate minus lim always lands in range.
  always_ff @(posedge clk) begin
    if (!clr) begin
      lim_q   <= '0;
      mask_q  <= '0;
      tries   <= '0;
      value_q <= '0;
    end else if (accept) begin
      lim_q  <= bus.limit;
      mask_q <= mask_for(bus.limit);
      tries  <= '0;
      if (bus.limit < WIDTH'(2)) value_q <= '0;
    end else if (fsm == DRAW) begin
      if (hit)           value_q <= cand;
      else if (last_try) value_q <= cand - lim_q;
      else               tries   <= tries + TW'(1);
    end
  end
endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: a cycle model of the default instance plus literal
// expectations, and a second instance (MAX_TRIES=1, no taps) for fallback and lock-up.
module tb_lfsr_rng;
  logic       clk = 1'b0;
  logic       clr;
  logic       en0, load0, en1, load1;
  logic [7:0] seed0, seed1;
  logic [7:0] state0, state1;
  logic       err0, err1;
  logic [1:0] dbg0, dbg1;
  int         checks = 0;
  int         errors = 0;
  bit         cmp_on = 1'b0;

  lfsr_rng_if #(.WIDTH(8)) b0 ();
  lfsr_rng_if #(.WIDTH(8)) b1 ();

  lfsr_rng dut0 (
    .clk(clk), .clr(clr), .en(en0), .load(load0), .seed(seed0), .bus(b0),
    .state_out(state0), .lockup_err(err0), .fsm_dbg(dbg0)
  );

  lfsr_rng #(.WIDTH(8), .TAPS(8'h00), .DEFAULT_SEED(8'h01), .MAX_TRIES(1)) dut1 (
    .clk(clk), .clr(clr), .en(en1), .load(load1), .seed(seed1), .bus(b1),
    .state_out(state1), .lockup_err(err1), .fsm_dbg(dbg1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model of dut0: draw as a transaction with an attempt count.
  logic [7:0] m_state, m_value;
  int         m_phase;   // 0 waiting for request, 1 drawing, 2 holding result
  int         m_lim, m_tries;
  bit         m_err;
  localparam int MT0 = 4;

  function automatic logic [7:0] model_next(input logic [7:0] s);
    int ones;
    ones = $countones(s & 8'hB8);
    return {s[6:0], 1'(ones % 2)};
  endfunction

  function automatic int model_mask(input int lim);
    int k;
    k = 0;
    while (((1 << k) - 1) < lim - 1) k++;
    return (1 << k) - 1;
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] cand;
    bit         drawing;
    if (!clr) begin
      m_state = 8'h01; m_phase = 0; m_value = 8'h00; m_err = 1'b0;
      m_lim = 0; m_tries = 0;
    end else begin
      drawing = (m_phase == 1);
      case (m_phase)
        0: if (b0.req) begin
             m_lim = int'(b0.limit); m_tries = 0;
             if (m_lim < 2) begin m_value = 8'h00; m_phase = 2; end
             else m_phase = 1;
           end
        1: begin
             cand = m_state & 8'(model_mask(m_lim));
             if (int'(cand) < m_lim) begin m_value = cand; m_phase = 2; end
             else if (m_tries == MT0 - 1) begin m_value = 8'(int'(cand) % m_lim); m_phase = 2; end
             else m_tries++;
           end
        default: if (b0.ack) m_phase = 0;
      endcase
      if (load0)                m_state = (seed0 == 8'h00) ? 8'h01 : seed0;
      else if (m_state == 8'h0) begin m_state = 8'h01; m_err = 1'b1; end
      else if (en0 || drawing)  m_state = model_next(m_state);
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_on) begin
      chk("m_state", state0, m_state);
      chk("m_ready", b0.ready, m_phase == 0);
      chk("m_valid", b0.valid, m_phase == 2);
      chk("m_lockup", err0, m_err);
      if (m_phase == 2) chk("m_value", b0.value, m_value);
    end
  end

  task automatic wait_valid0(input int budget);
    int n;
    n = 0;
    while (b0.valid !== 1'b1 && n < budget) begin tick(1); n++; end
    chk("valid0_timeout", b0.valid === 1'b1, 1);
  endtask

  task automatic take0;
    b0.ack = 1'b1; tick(1); b0.ack = 1'b0;
  endtask

  initial begin
    logic [7:0] step_exp [4];
    logic [7:0] lims [6];
    bit         seen [256];
    int         distinct;
    step_exp = '{8'h02, 8'h04, 8'h08, 8'h11};
    lims     = '{8'd7, 8'd200, 8'd2, 8'd255, 8'd128, 8'd3};
    clr = 1'b0; en0 = 1'b0; load0 = 1'b0; seed0 = 8'h00;
    en1 = 1'b0; load1 = 1'b0; seed1 = 8'h00;
    b0.req = 1'b0; b0.limit = 8'h00; b0.ack = 1'b0;
    b1.req = 1'b0; b1.limit = 8'h00; b1.ack = 1'b0;
    tick(1);
    cmp_on = 1'b1;
    chk("rst_state", state0, 8'h01);
    chk("rst_ready", b0.ready, 1);
    chk("rst_valid", b0.valid, 0);
    chk("rst_value", b0.value, 8'h00);
    chk("rst_lockup", err0, 0);
    chk("rst_state1", state1, 8'h01);

    // Full period walk from the default seed.
    clr = 1'b1; en0 = 1'b1;
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick(1);
      if (i < 4) chk("step", state0, step_exp[i]);
      if (!seen[state0]) begin seen[state0] = 1'b1; distinct++; end
    end
    chk("period_state", state0, 8'h01);
    chk("period_distinct", distinct, 255);

    // Load wins over step; a zero seed falls back to the default.
    load0 = 1'b1; seed0 = 8'h5A; tick(1);
    chk("load_5a", state0, 8'h5A);
    en0 = 1'b0; seed0 = 8'h00; tick(1);
    chk("load_zero", state0, 8'h01);
    load0 = 1'b0;

    // Draw limit=10 from state 01 with a slow consumer.
    b0.req = 1'b1; b0.limit = 8'd10; tick(1); b0.req = 1'b0;
    chk("draw_ready_low", b0.ready, 0);
    chk("draw_not_yet", b0.valid, 0);
    tick(1);
    chk("draw_valid", b0.valid, 1);
    chk("draw_value", b0.value, 8'd1);
    chk("draw_stepped", state0, 8'h02);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("hold_valid", b0.valid, 1);
      chk("hold_value", b0.value, 8'd1);
    end
    take0();
    chk("ack_ready", b0.ready, 1);
    chk("ack_valid", b0.valid, 0);

    // Degenerate limits complete immediately without stepping.
    for (int l = 0; l < 2; l++) begin
      b0.req = 1'b1; b0.limit = 8'(l); tick(1); b0.req = 1'b0;
      chk("lim01_valid", b0.valid, 1);
      chk("lim01_value", b0.value, 8'h00);
      chk("lim01_nostep", state0, 8'h02);
      take0();
    end

    // Load and request together: first candidate uses the loaded seed.
    load0 = 1'b1; seed0 = 8'h33; b0.req = 1'b1; b0.limit = 8'd3; tick(1);
    load0 = 1'b0; b0.req = 1'b0;
    chk("lr_state", state0, 8'h33);
    tick(1);
    chk("lr_reject", b0.valid, 0);
    chk("lr_state2", state0, 8'h66);
    tick(1);
    chk("lr_valid", b0.valid, 1);
    chk("lr_value", b0.value, 8'd2);
    take0();

    // Assorted limits with free-run toggling, checked against the model.
    foreach (lims[i]) begin
      en0 = 1'(i % 2);
      b0.req = 1'b1; b0.limit = lims[i]; tick(1); b0.req = 1'b0;
      wait_valid0(8);
      chk("bound", b0.value < lims[i], 1);
      tick(i % 3);
      take0();
    end
    en0 = 1'b0;

    // Reset abandons a draw in flight.
    b0.req = 1'b1; b0.limit = 8'd200; tick(1); b0.req = 1'b0;
    clr = 1'b0; tick(1); clr = 1'b1;
    chk("clr_valid", b0.valid, 0);
    chk("clr_ready", b0.ready, 1);
    chk("clr_state", state0, 8'h01);

    // Single-try fallback on dut1: cand 15 vs limit 9 gives 6.
    load1 = 1'b1; seed1 = 8'h0F; b1.req = 1'b1; b1.limit = 8'd9; tick(1);
    load1 = 1'b0; b1.req = 1'b0;
    chk("fb_ready_low", b1.ready, 0);
    tick(1);
    chk("fb_valid", b1.valid, 1);
    chk("fb_value", b1.value, 8'd6);
    b1.ack = 1'b1; tick(1); b1.ack = 1'b0;
    chk("fb_ready", b1.ready, 1);

    // No taps: shifting out the seed reaches zero, which is repaired.
    load1 = 1'b1; seed1 = 8'h01; tick(1); load1 = 1'b0; en1 = 1'b1;
    tick(7);
    chk("lk_80", state1, 8'h80);
    tick(1);
    chk("lk_zero", state1, 8'h00);
    chk("lk_err_pre", err1, 0);
    tick(1);
    chk("lk_repair", state1, 8'h01);
    chk("lk_err", err1, 1);
    en1 = 1'b0; tick(2);
    chk("lk_sticky", err1, 1);
    clr = 1'b0; tick(1); clr = 1'b1;
    chk("lk_cleared", err1, 0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
